// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_RUN  = 2'd1,
    MD_ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_iterative(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_divide(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or restoring divide.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Multiply: acc = {partial product, remaining multiplier bits}; add when the LSB is set.
  assign w_sum = i_acc[0] ? ({1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd})
                          : {1'b0, i_acc[2*WIDTH-1:WIDTH]};

  // Divide: acc = {partial remainder, dividend/quotient bits}; the low W bits of the
  // difference are exact whenever the trial subtraction succeeds.
  assign w_shift = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge    = (w_shift >= {1'b0, i_opnd});
  assign w_diff  = w_shift[WIDTH-1:0] - i_opnd;

  always_comb begin
    o_acc = '0;
    if (i_is_div) begin
      o_acc = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO; one result bit per cycle.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = MD_ST_IDLE;
  localparam logic [1:0] S_RUN  = MD_ST_RUN;
  localparam logic [1:0] S_FIX  = MD_ST_FIX;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic             w_op_div;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [W2-1:0]    w_step_acc;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_signed = md_is_signed(i_op);
  assign w_op_div = md_is_divide(i_op);
  assign w_sa     = w_signed & i_a[WIDTH-1];
  assign w_sb     = w_signed & i_b[WIDTH-1];
  assign w_mag_a  = w_sa ? (~i_a + 1'b1) : i_a;
  assign w_mag_b  = w_sb ? (~i_b + 1'b1) : i_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign correction: LO/product takes sa^sb, the remainder follows the dividend.
  assign w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? (~r_acc[W2-1:WIDTH] + 1'b1) : r_acc[W2-1:WIDTH];

  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (!r_is_div) begin
      w_fix_hi = w_prod[W2-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_div_zero) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a_raw    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A flush in the same cycle drops the request, MTHI/MTLO included.
          if (i_start && !i_flush) begin
            if (md_is_iterative(i_op)) begin
              r_state    <= S_RUN;
              r_busy     <= 1'b1;
              r_cnt      <= CW'(WIDTH - 1);
              r_is_div   <= w_op_div;
              r_acc      <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
              r_opnd     <= w_op_div ? w_mag_b : w_mag_a;
              r_neg_lo   <= w_sa ^ w_sb;
              r_neg_hi   <= w_op_div & w_sa;
              r_div_zero <= w_op_div && (i_b == '0);
              r_a_raw    <= i_a;
            end else if (i_op == MD_MTHI) begin
              r_hi <= i_a;
            end else if (i_op == MD_MTLO) begin
              r_lo <= i_a;
            end
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of iterative ops plus flush/reset/MTHI sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op_s),
    .i_a     (a_s),
    .i_b     (b_s),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge, then samples busy/done for 40 cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int ndone);
    @(negedge clk);
    start = 1'b1; op_s = op; a_s = a; b_s = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_op(input logic [2:0] op, input logic [31:0] a, input logic fl);
    @(negedge clk);
    start = 1'b1; op_s = op; a_s = a; b_s = 32'd0; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int nb;
    int nd;
    int cyc;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{MD_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    rst = 1'b1; start = 1'b0; op_s = 3'd0; a_s = '0; b_s = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // MTHI/MTLO are single-cycle writes with no busy/done.
    pulse_op(MD_MTHI, 32'hA5A5A5A5, 1'b0);
    chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    pulse_op(MD_MTLO, 32'h11111111, 1'b0);
    chk("mtlo_lo", 64'(lo), 64'h11111111);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);

    pulse_op(3'd6, 32'hDEADBEEF, 1'b0);
    chk("rsvd_busy", 64'(busy), 64'd0);
    chk("rsvd_hilo", {hi, lo}, {32'hA5A5A5A5, 32'h11111111});

    // MULT aborted by flush; a start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op_s = MD_MULT; a_s = 32'd3; b_s = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      if (cyc == 5) begin
        start = 1'b1; op_s = MD_MTHI; a_s = 32'h0000DEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("flush_pre_busy", 64'(busy), 64'd1);
    chk("busy_start_ignored", 64'(hi), 64'hA5A5A5A5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_hilo", {hi, lo}, {32'hA5A5A5A5, 32'h11111111});

    pulse_op(MD_MTHI, 32'h00000001, 1'b1);
    chk("flush_start_mthi", 64'(hi), 64'hA5A5A5A5);
    pulse_op(MD_MULT, 32'd2, 1'b1);
    chk("flush_start_mult", 64'(busy), 64'd0);

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, nb, nd);
      chk($sformatf("vec%0d_hi", v), 64'(hi), 64'(vecs[v].hi));
      chk($sformatf("vec%0d_lo", v), 64'(lo), 64'(vecs[v].lo));
      chk($sformatf("vec%0d_busy_cycles", v), 64'(nb), 64'd33);
      chk($sformatf("vec%0d_done_pulses", v), 64'(nd), 64'd1);
      $display("vec%0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d done=%0d",
               v, vecs[v].op, vecs[v].a, vecs[v].b, hi, lo, nb, nd);
    end

    // Asynchronous reset in the middle of RUN.
    pulse_op(MD_MTHI, 32'h00000077, 1'b0);
    @(negedge clk);
    start = 1'b1; op_s = MD_DIVU; a_s = 32'd1000; b_s = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("prerst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(MD_DIVU, 32'd1000, 32'd3, nb, nd);
    chk("postrst_hilo", {hi, lo}, {32'd1, 32'd333});
    chk("postrst_busy_cycles", 64'(nb), 64'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
